// File: rtl/sm_mem_arbiter_pkg.sv
// Shared constants and types for the two-port memory arbiter.
package sm_mem_arbiter_pkg;

   localparam int unsigned SM_ARB_ADDR_W = 8;
   localparam int unsigned SM_ARB_DATA_W = 32;
   localparam int unsigned SM_ARB_CNT_W  = 16;

   // Requester index: P0 = CPU fetch side, P1 = debug/loader side.
   typedef enum logic {
      SM_ARB_P0 = 1'b0,
      SM_ARB_P1 = 1'b1
   } sm_arb_port_e;

endpackage

// File: rtl/sm_mem_arbiter_if.sv
// Requester and memory-macro signals of the arbiter, grouped in one bundle.
interface sm_mem_arbiter_if
   import sm_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = SM_ARB_ADDR_W,
   parameter int unsigned DATA_WIDTH = SM_ARB_DATA_W,
   parameter int unsigned CNT_WIDTH  = SM_ARB_CNT_W
);
   logic                  m0_req;
   logic                  m0_we;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0] m0_wdata;
   logic                  m0_gnt;
   logic                  m0_rvalid;
   logic [DATA_WIDTH-1:0] m0_rdata;

   logic                  m1_req;
   logic                  m1_we;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0] m1_wdata;
   logic                  m1_lock;
   logic                  m1_gnt;
   logic                  m1_rvalid;
   logic [DATA_WIDTH-1:0] m1_rdata;

   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic [CNT_WIDTH-1:0]  conflict_cnt;

   // Arbiter side.
   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
      input  mem_rdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output conflict_cnt
   );

   // Requesters plus memory macro side.
   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
      output mem_rdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  conflict_cnt
   );

endinterface

// File: rtl/sm_arb_rr2.sv
// Two-way round-robin grant with a tie-winning lock for port 1.
module sm_arb_rr2
   import sm_mem_arbiter_pkg::*;
(
   input  logic         i_req0,
   input  logic         i_req1,
   input  sm_arb_port_e i_last,
   input  logic         i_lock,
   output logic         o_gnt0_c,
   output logic         o_gnt1_c
);

   // Lone requester always wins; ties go to the port not served last unless P1 holds the lock.
   always_comb begin
      o_gnt0_c = 1'b0;
      o_gnt1_c = 1'b0;
      if (i_req0 && i_req1) begin
         if ((i_lock && (i_last == SM_ARB_P1)) || (i_last == SM_ARB_P0)) begin
            o_gnt1_c = 1'b1;
         end else begin
            o_gnt0_c = 1'b1;
         end
      end else begin
         o_gnt0_c = i_req0;
         o_gnt1_c = i_req1;
      end
   end

endmodule

// File: rtl/sm_mem_arbiter.sv
// Shares one single-port synchronous memory between CPU (P0) and loader (P1).
module sm_mem_arbiter
   import sm_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = SM_ARB_ADDR_W,
   parameter int unsigned DATA_WIDTH = SM_ARB_DATA_W,
   parameter int unsigned CNT_WIDTH  = SM_ARB_CNT_W
)
(
   input  logic             clk,
   input  logic             rst_n,
   sm_mem_arbiter_if.slave  bus
);

   logic                  w_req0;
   logic                  w_req1;
   logic                  w_gnt0;
   logic                  w_gnt1;
   logic                  w_en;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   sm_arb_port_e          w_idx;

   sm_arb_port_e          r_last;
   sm_arb_port_e          r_owner;
   logic                  r_lock;
   logic                  r_rvalid;
   logic [CNT_WIDTH-1:0]  r_cnt;

   // Requests are masked during reset so no grant or strobe escapes.
   assign w_req0 = bus.m0_req & rst_n;
   assign w_req1 = bus.m1_req & rst_n;

   sm_arb_rr2 u_rr2 (
      .i_req0   (w_req0),
      .i_req1   (w_req1),
      .i_last   (r_last),
      .i_lock   (r_lock),
      .o_gnt0_c (w_gnt0),
      .o_gnt1_c (w_gnt1)
   );

   // Memory port mux: granted port drives the macro, idle defaults to P0 with writes off.
   always_comb begin
      w_en    = w_gnt0 | w_gnt1;
      w_idx   = SM_ARB_P0;
      w_we    = w_gnt0 & bus.m0_we;
      w_addr  = bus.m0_addr;
      w_wdata = bus.m0_wdata;
      if (w_gnt1) begin
         w_idx   = SM_ARB_P1;
         w_we    = bus.m1_we;
         w_addr  = bus.m1_addr;
         w_wdata = bus.m1_wdata;
      end
   end

   assign bus.m0_gnt    = w_gnt0;
   assign bus.m1_gnt    = w_gnt1;
   assign bus.mem_en    = w_en;
   assign bus.mem_we    = w_we;
   assign bus.mem_addr  = w_addr;
   assign bus.mem_wdata = w_wdata;

   // Arbitration history and read-response tag, updated only on granted cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last   <= SM_ARB_P1;
         r_owner  <= SM_ARB_P0;
         r_lock   <= 1'b0;
         r_rvalid <= 1'b0;
      end else if (w_en) begin
         r_last   <= w_idx;
         r_owner  <= w_idx;
         r_lock   <= bus.m1_lock & w_gnt1;
         r_rvalid <= ~w_we;
      end else begin
         r_rvalid <= 1'b0;
      end
   end

   // Read data arrives one cycle after the strobe; route valid to the owning port.
   assign bus.m0_rvalid = r_rvalid & (r_owner == SM_ARB_P0);
   assign bus.m1_rvalid = r_rvalid & (r_owner == SM_ARB_P1);
   assign bus.m0_rdata  = bus.mem_rdata;
   assign bus.m1_rdata  = bus.mem_rdata;

   // Saturating count of cycles where both ports are asking at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (bus.m0_req && bus.m1_req && (r_cnt != {CNT_WIDTH{1'b1}})) begin
         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   assign bus.conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// Randomized and directed bench for sm_mem_arbiter against a behavioural model.
module tb_sm_mem_arbiter;

   localparam int unsigned AW  = 8;
   localparam int unsigned DW  = 32;
   localparam int unsigned CW  = 16;
   localparam int unsigned CWS = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   sm_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW))  bus ();
   sm_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CWS)) bus_s ();

   sm_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Second instance with a narrow counter, fed the same stimulus, for saturation.
   sm_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CWS)) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_s.slave)
   );

   assign bus_s.m0_req    = bus.m0_req;
   assign bus_s.m0_we     = bus.m0_we;
   assign bus_s.m0_addr   = bus.m0_addr;
   assign bus_s.m0_wdata  = bus.m0_wdata;
   assign bus_s.m1_req    = bus.m1_req;
   assign bus_s.m1_we     = bus.m1_we;
   assign bus_s.m1_addr   = bus.m1_addr;
   assign bus_s.m1_wdata  = bus.m1_wdata;
   assign bus_s.m1_lock   = bus.m1_lock;
   assign bus_s.mem_rdata = bus.mem_rdata;

   // Memory macro: synchronous single port, read data one cycle after the strobe.
   logic [DW-1:0] macro_mem [256];
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) macro_mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= macro_mem[bus.mem_addr];
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // Behavioural model state.
   int            m_last = 1;
   bit            m_lock = 1'b0;
   bit            m_pv   = 1'b0;
   int            m_pp   = 0;
   logic [DW-1:0] m_pd   = '0;
   int            m_cnt  = 0;
   int            m_cnts = 0;
   logic [DW-1:0] shadow [256];

   // Which port must be granted right now (-1 = none).
   function automatic int exp_gnt();
      if (!rst_n) return -1;
      if (bus.m0_req && bus.m1_req) begin
         if (m_lock && (m_last == 1)) return 1;
         return (m_last == 0) ? 1 : 0;
      end
      if (bus.m0_req) return 0;
      if (bus.m1_req) return 1;
      return -1;
   endfunction

   // Model update at each clock edge, cleared by async reset.
   always @(posedge clk or negedge rst_n) begin : model
      int            g;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      if (!rst_n) begin
         m_last <= 1;
         m_lock <= 1'b0;
         m_pv   <= 1'b0;
         m_pp   <= 0;
         m_cnt  <= 0;
         m_cnts <= 0;
      end else begin
         g = exp_gnt();
         if (bus.m0_req && bus.m1_req) begin
            if (m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (m_cnts < 15)   m_cnts <= m_cnts + 1;
         end
         if (g >= 0) begin
            we = (g == 1) ? bus.m1_we    : bus.m0_we;
            a  = (g == 1) ? bus.m1_addr  : bus.m0_addr;
            d  = (g == 1) ? bus.m1_wdata : bus.m0_wdata;
            m_last <= g;
            m_lock <= (g == 1) && bus.m1_lock;
            m_pv   <= !we;
            m_pp   <= g;
            if (we) shadow[a] <= d;
            else    m_pd <= shadow[a];
         end else begin
            m_pv <= 1'b0;
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin : compare
      int g;
      g = exp_gnt();
      check("m0_gnt", 64'(bus.m0_gnt), 64'(g == 0));
      check("m1_gnt", 64'(bus.m1_gnt), 64'(g == 1));
      check("mem_en", 64'(bus.mem_en), 64'(g >= 0));
      check("mem_we", 64'(bus.mem_we),
            64'((g == 1) ? bus.m1_we : ((g == 0) ? bus.m0_we : 1'b0)));
      check("mem_addr",  64'(bus.mem_addr),  64'((g == 1) ? bus.m1_addr  : bus.m0_addr));
      check("mem_wdata", 64'(bus.mem_wdata), 64'((g == 1) ? bus.m1_wdata : bus.m0_wdata));
      check("m0_rvalid", 64'(bus.m0_rvalid), 64'(m_pv && (m_pp == 0)));
      check("m1_rvalid", 64'(bus.m1_rvalid), 64'(m_pv && (m_pp == 1)));
      if (m_pv && (m_pp == 0)) check("m0_rdata", 64'(bus.m0_rdata), 64'(m_pd));
      if (m_pv && (m_pp == 1)) check("m1_rdata", 64'(bus.m1_rdata), 64'(m_pd));
      check("conflict_cnt",   64'(bus.conflict_cnt),   64'(m_cnt));
      check("conflict_cnt_s", 64'(bus_s.conflict_cnt), 64'(m_cnts));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
   endtask

   task automatic drive1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
   endtask

   // Directed scenarios followed by constrained-random traffic.
   initial begin : stim
      logic g0, g1, fresh;
      drive0(1'b0, 1'b0, '0, '0);
      drive1(1'b0, 1'b0, '0, '0);
      bus.m1_lock = 1'b0;
      #1 rst_n = 1'b0;

      // Reset: requests present but nothing may be granted.
      drive0(1'b1, 1'b0, 8'h01, '0);
      drive1(1'b1, 1'b0, 8'h02, '0);
      @(negedge clk);
      check("rst_m0_gnt", 64'(bus.m0_gnt), 64'd0);
      check("rst_m1_gnt", 64'(bus.m1_gnt), 64'd0);
      check("rst_mem_en", 64'(bus.mem_en), 64'd0);
      check("rst_cnt",    64'(bus.conflict_cnt), 64'd0);
      step();
      drive0(1'b0, 1'b0, '0, '0);
      drive1(1'b0, 1'b0, '0, '0);
      rst_n = 1'b1;
      step();

      // Loader fills the whole memory through port 1.
      for (int i = 0; i < 256; i++) begin
         drive1(1'b1, 1'b1, 8'(i), (i == 16) ? 32'hDEADBEEF : $urandom);
         step();
      end
      drive1(1'b0, 1'b0, '0, '0);

      // Single read from port 0.
      drive0(1'b1, 1'b0, 8'h10, '0);
      @(negedge clk);
      check("rd_gnt",  64'(bus.m0_gnt),   64'd1);
      check("rd_en",   64'(bus.mem_en),   64'd1);
      check("rd_addr", 64'(bus.mem_addr), 64'h10);
      step();
      drive0(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("rd_rvalid", 64'(bus.m0_rvalid), 64'd1);
      check("rd_rdata",  64'(bus.m0_rdata),  64'hDEADBEEF);
      check("rd_m1_rv",  64'(bus.m1_rvalid), 64'd0);
      step();

      // Fresh reset, then tie alternation P0,P1,P0,P1.
      rst_n = 1'b0; #2 rst_n = 1'b1;
      drive0(1'b1, 1'b0, 8'h01, '0);
      drive1(1'b1, 1'b0, 8'h02, '0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("alt_gnt0", 64'(bus.m0_gnt), 64'((k % 2) == 0));
         check("alt_gnt1", 64'(bus.m1_gnt), 64'((k % 2) == 1));
         step();
      end
      drive0(1'b0, 1'b0, '0, '0);
      drive1(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("alt_cnt",   64'(bus.conflict_cnt), 64'd4);
      check("alt_m1_rv", 64'(bus.m1_rvalid),    64'd1);
      step();

      // Lock burst: P0, then P1 three times, then P0 once lock drops.
      drive0(1'b1, 1'b0, 8'h03, '0);
      drive1(1'b1, 1'b0, 8'h04, '0);
      @(negedge clk); check("lk_a_gnt0", 64'(bus.m0_gnt), 64'd1); step();
      bus.m1_lock = 1'b1;
      @(negedge clk); check("lk_b_gnt1", 64'(bus.m1_gnt), 64'd1); step();
      @(negedge clk); check("lk_c_gnt1", 64'(bus.m1_gnt), 64'd1); step();
      bus.m1_lock = 1'b0;
      @(negedge clk); check("lk_d_gnt1", 64'(bus.m1_gnt), 64'd1); step();
      @(negedge clk); check("lk_e_gnt0", 64'(bus.m0_gnt), 64'd1); step();
      drive0(1'b0, 1'b0, '0, '0);
      drive1(1'b0, 1'b0, '0, '0);
      step();

      // Port 1 write then port 0 read of the same word.
      drive1(1'b1, 1'b1, 8'h05, 32'h12345678);
      step();
      drive1(1'b0, 1'b0, '0, '0);
      drive0(1'b1, 1'b0, 8'h05, '0);
      @(negedge clk);
      check("wr_m1_rv", 64'(bus.m1_rvalid), 64'd0);
      step();
      drive0(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("wr_rd_rv",   64'(bus.m0_rvalid), 64'd1);
      check("wr_rd_data", 64'(bus.m0_rdata),  64'h12345678);
      step();

      // Saturation of the narrow counter.
      drive0(1'b1, 1'b0, 8'h06, '0);
      drive1(1'b1, 1'b0, 8'h07, '0);
      repeat (20) step();
      drive0(1'b0, 1'b0, '0, '0);
      drive1(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("sat_cnt", 64'(bus_s.conflict_cnt), 64'd15);
      step();

      // Async reset between a read grant and its rvalid.
      drive0(1'b1, 1'b0, 8'h10, '0);
      step();
      drive1(1'b1, 1'b0, 8'h08, '0);
      #2 rst_n = 1'b0;
      #1;
      check("ar_m0_gnt", 64'(bus.m0_gnt),       64'd0);
      check("ar_m1_gnt", 64'(bus.m1_gnt),       64'd0);
      check("ar_m0_rv",  64'(bus.m0_rvalid),    64'd0);
      check("ar_cnt",    64'(bus.conflict_cnt), 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("ar_tie_gnt0", 64'(bus.m0_gnt), 64'd1);
      check("ar_tie_gnt1", 64'(bus.m1_gnt), 64'd0);
      step();
      drive0(1'b0, 1'b0, '0, '0);
      drive1(1'b0, 1'b0, '0, '0);
      step();

      // Random traffic honouring the hold-until-granted rule, with rare resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         g0 = bus.m0_gnt;
         g1 = bus.m1_gnt;
         step();
         fresh = 1'b0;
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0; #2 rst_n = 1'b1;
            fresh = 1'b1;
         end
         if (fresh || !bus.m0_req || g0 || ($urandom_range(0, 7) == 0))
            drive0(1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 3) == 0),
                   8'($urandom), $urandom);
         if (fresh || !bus.m1_req || g1 || ($urandom_range(0, 7) == 0))
            drive1(1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 3) == 0),
                   8'($urandom), $urandom);
         bus.m1_lock = 1'($urandom_range(0, 2) == 0);
      end

      drive0(1'b0, 1'b0, '0, '0);
      drive1(1'b0, 1'b0, '0, '0);
      bus.m1_lock = 1'b0;
      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
